// File: rtl/hart_debug_unit.sv
// hart_debug_unit: core-side halt/resume and abstract register access.
// Drains the pipeline on halt, serves GPR/dcsr/dpc accesses, redirects on resume.
module hart_debug_unit #(
  parameter int XPR_LEN = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               haltreq,
  input  logic               resumereq,
  output logic               core_haltack,
  output logic               resumeack,
  input  logic [12:0]        register_index,
  input  logic               debug_read,
  input  logic               debug_write,
  input  logic [XPR_LEN-1:0] debug_wdata,
  output logic [XPR_LEN-1:0] debug_rdata,
  output logic               debug_done,
  output logic               debug_err,
  output logic               pipe_stall,
  input  logic               pipe_empty,
  input  logic [XPR_LEN-1:0] core_pc,
  output logic               redirect_valid,
  output logic [XPR_LEN-1:0] redirect_pc,
  output logic [4:0]         rf_addr,
  input  logic [XPR_LEN-1:0] rf_rdata,
  output logic               rf_wen,
  output logic [XPR_LEN-1:0] rf_wdata
);

  typedef enum logic [2:0] {
    RUNNING,
    HALTING,
    HALTED,
    ACCESS,
    DONE_WAIT,
    RESUMING
  } state_e;

  localparam logic [31:0] DCSR_RST   = 32'h4000_0003;
  localparam logic [31:0] DCSR_WMASK = 32'h0000_F007;

  state_e             state_q, state_d;
  logic               org_halted_q, org_halted_d;
  logic [XPR_LEN-1:0] dpc_q, dpc_d;
  logic [31:0]        dcsr_q, dcsr_d;
  logic [XPR_LEN-1:0] rdata_q, rdata_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  logic req;
  logic is_gpr;
  logic is_dcsr;
  logic is_dpc;
  logic legal;
  logic halted_side;

  assign req     = debug_read | debug_write;
  assign is_gpr  = (register_index[12:5] == 8'h80);
  assign is_dcsr = (register_index == 13'h07B0);
  assign is_dpc  = (register_index == 13'h07B1);
  assign legal   = is_gpr | is_dcsr | is_dpc;

  // Halted-side states keep the pipeline frozen and the ack raised.
  assign halted_side = (state_q == HALTED) ||
                       (state_q == ACCESS) ||
                       ((state_q == DONE_WAIT) && org_halted_q);

  // State register and debug CSRs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= RUNNING;
      org_halted_q <= 1'b0;
      dpc_q        <= '0;
      dcsr_q       <= DCSR_RST;
      rdata_q      <= '0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      org_halted_q <= org_halted_d;
      dpc_q        <= dpc_d;
      dcsr_q       <= dcsr_d;
      rdata_q      <= rdata_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  // Next-state, CSR updates and the registered completion pulse.
  always_comb begin
    state_d      = state_q;
    org_halted_d = org_halted_q;
    dpc_d        = dpc_q;
    dcsr_d       = dcsr_q;
    rdata_d      = rdata_q;
    done_d       = 1'b0;
    err_d        = 1'b0;
    unique case (state_q)
      RUNNING: begin
        if (haltreq) begin
          state_d = HALTING;
        end else if (req) begin
          done_d       = 1'b1;
          err_d        = 1'b1;
          org_halted_d = 1'b0;
          state_d      = DONE_WAIT;
        end
      end
      HALTING: begin
        if (pipe_empty) begin
          dpc_d       = core_pc;
          dcsr_d[8:6] = 3'd3;
          state_d     = HALTED;
        end
      end
      HALTED: begin
        if (req) begin
          org_halted_d = 1'b1;
          if (legal) begin
            state_d = ACCESS;
          end else begin
            done_d  = 1'b1;
            err_d   = 1'b1;
            state_d = DONE_WAIT;
          end
        end else if (resumereq && !haltreq) begin
          state_d = RESUMING;
        end
      end
      ACCESS: begin
        done_d  = 1'b1;
        state_d = DONE_WAIT;
        if (debug_write) begin
          if (is_dcsr) begin
            dcsr_d = (dcsr_q & ~DCSR_WMASK) |
                     (debug_wdata[31:0] & DCSR_WMASK);
          end else if (is_dpc) begin
            dpc_d = debug_wdata;
          end
        end else begin
          if (is_gpr) begin
            rdata_d = rf_rdata;
          end else if (is_dcsr) begin
            rdata_d = XPR_LEN'(dcsr_q);
          end else begin
            rdata_d = dpc_q;
          end
        end
      end
      DONE_WAIT: begin
        if (!req) begin
          state_d = org_halted_q ? HALTED : RUNNING;
        end
      end
      RESUMING: begin
        state_d = RUNNING;
      end
      default: begin
        state_d = RUNNING;
      end
    endcase
  end

  // Outputs decoded from the current state.
  always_comb begin
    pipe_stall     = (state_q == HALTING) || halted_side;
    core_haltack   = halted_side;
    resumeack      = (state_q == RESUMING);
    redirect_valid = (state_q == RESUMING);
    redirect_pc    = (state_q == RESUMING) ? dpc_q : '0;
    rf_addr        = ((state_q == HALTED) || (state_q == ACCESS)) ?
                     register_index[4:0] : 5'd0;
    rf_wen         = reset && (state_q == ACCESS) &&
                     debug_write && is_gpr;
    rf_wdata       = rf_wen ? debug_wdata : '0;
    debug_done     = done_q;
    debug_err      = err_q;
    debug_rdata    = rdata_q;
  end

endmodule

// File: tb/tb_hart_debug_unit.sv
// tb_hart_debug_unit: randomized scoreboard bench for hart_debug_unit.
// Transaction-level model predicts completions, GPR writes and redirects.
module tb_hart_debug_unit;

  logic        clk;
  logic        reset;
  logic        haltreq;
  logic        resumereq;
  logic        core_haltack;
  logic        resumeack;
  logic [12:0] register_index;
  logic        debug_read;
  logic        debug_write;
  logic [31:0] debug_wdata;
  logic [31:0] debug_rdata;
  logic        debug_done;
  logic        debug_err;
  logic        pipe_stall;
  logic        pipe_empty;
  logic [31:0] core_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [4:0]  rf_addr;
  logic [31:0] rf_rdata;
  logic        rf_wen;
  logic [31:0] rf_wdata;

  hart_debug_unit #(.XPR_LEN(32)) dut (
    .clk            (clk),
    .reset          (reset),
    .haltreq        (haltreq),
    .resumereq      (resumereq),
    .core_haltack   (core_haltack),
    .resumeack      (resumeack),
    .register_index (register_index),
    .debug_read     (debug_read),
    .debug_write    (debug_write),
    .debug_wdata    (debug_wdata),
    .debug_rdata    (debug_rdata),
    .debug_done     (debug_done),
    .debug_err      (debug_err),
    .pipe_stall     (pipe_stall),
    .pipe_empty     (pipe_empty),
    .core_pc        (core_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .rf_addr        (rf_addr),
    .rf_rdata       (rf_rdata),
    .rf_wen         (rf_wen),
    .rf_wdata       (rf_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          err;
    bit          chk;
    logic [31:0] data;
  } done_t;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  done_t       exp_done[$];
  wr_t         exp_wr[$];
  logic [31:0] exp_redir[$];

  int checks = 0;
  int errors = 0;
  bit mon_en = 0;

  // Reference model state
  bit          m_halted;
  logic [31:0] m_dpc;
  logic [31:0] m_dcsr;
  logic [31:0] ref_gpr [32];

  // Register file environment: synchronous read, x0 hardwired to zero
  logic [31:0] rf_mem [32];
  always @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) rf_mem[i] <= '0;
    end else if (rf_wen && rf_addr != 5'd0) begin
      rf_mem[rf_addr] <= rf_wdata;
    end
    rf_rdata <= rf_mem[rf_addr];
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops expectations whenever the DUT presents an event
  always @(negedge clk) begin
    if (mon_en) begin
      if (debug_done) begin
        if (exp_done.size() == 0) begin
          chk("unexpected_done", 32'(debug_done), 32'd0);
        end else begin
          done_t e;
          e = exp_done.pop_front();
          chk("done_err", 32'(debug_err), 32'(e.err));
          if (e.chk) chk("debug_rdata", debug_rdata, e.data);
        end
      end
      if (rf_wen) begin
        if (exp_wr.size() == 0) begin
          chk("unexpected_rf_wen", 32'(rf_wen), 32'd0);
        end else begin
          wr_t w;
          w = exp_wr.pop_front();
          chk("rf_addr", 32'(rf_addr), 32'(w.addr));
          chk("rf_wdata", rf_wdata, w.data);
        end
      end
      if (redirect_valid) begin
        if (exp_redir.size() == 0) begin
          chk("unexpected_redirect", 32'(redirect_valid), 32'd0);
        end else begin
          chk("redirect_pc", redirect_pc, exp_redir.pop_front());
          chk("resumeack_with_redirect", 32'(resumeack), 32'd1);
        end
      end
    end
  end

  task automatic model_reset();
    m_halted = 0;
    m_dpc    = '0;
    m_dcsr   = 32'h4000_0003;
    for (int i = 0; i < 32; i++) ref_gpr[i] = '0;
  endtask

  task automatic check_outputs_zero(input string nm);
    chk({nm, "_ctl"}, 32'({core_haltack, resumeack, debug_done,
                           debug_err, pipe_stall, redirect_valid,
                           rf_wen}), 32'd0);
    chk({nm, "_rdata"}, debug_rdata, 32'd0);
    chk({nm, "_redirect_pc"}, redirect_pc, 32'd0);
    chk({nm, "_rf_addr"}, 32'(rf_addr), 32'd0);
    chk({nm, "_rf_wdata"}, rf_wdata, 32'd0);
  endtask

  task automatic halt(input logic [31:0] pc, input int delay);
    core_pc    = pc;
    pipe_empty = (delay == 0);
    haltreq    = 1'b1;
    tick();
    chk("halt_stall_n1", 32'(pipe_stall), 32'd1);
    chk("halt_ack_n1", 32'(core_haltack), 32'd0);
    for (int i = 0; i < delay; i++) begin
      tick();
      chk("drain_stall", 32'(pipe_stall), 32'd1);
      chk("drain_ack", 32'(core_haltack), 32'd0);
    end
    pipe_empty = 1'b1;
    tick();
    chk("halt_ack", 32'(core_haltack), 32'd1);
    chk("halt_stall", 32'(pipe_stall), 32'd1);
    haltreq  = 1'b0;
    m_halted = 1;
    m_dpc    = pc;
    m_dcsr   = (m_dcsr & ~32'h0000_01C0) | 32'h0000_00C0;
  endtask

  task automatic access(input bit rd, input bit wr,
                        input logic [12:0] idx,
                        input logic [31:0] wd);
    bit          gpr;
    bit          legal;
    int          exp_lat;
    int          lat;
    done_t       d;
    wr_t         w;
    gpr   = (idx >= 13'h1000) && (idx <= 13'h101F);
    legal = gpr || idx == 13'h07B0 || idx == 13'h07B1;
    d.err = 0; d.chk = 0; d.data = '0;
    if (!m_halted || !legal) begin
      exp_lat = 1;
      d.err   = 1;
    end else begin
      exp_lat = 2;
      if (wr) begin
        if (gpr) begin
          w.addr = idx[4:0];
          w.data = wd;
          exp_wr.push_back(w);
          if (idx[4:0] != 5'd0) ref_gpr[idx[4:0]] = wd;
        end else if (idx == 13'h07B0) begin
          m_dcsr = (m_dcsr & ~32'h0000_F007) | (wd & 32'h0000_F007);
        end else begin
          m_dpc = wd;
        end
      end else begin
        d.chk  = 1;
        d.data = gpr ? ref_gpr[idx[4:0]] :
                 (idx == 13'h07B0) ? m_dcsr : m_dpc;
      end
    end
    exp_done.push_back(d);
    register_index = idx;
    debug_wdata    = wd;
    debug_read     = rd;
    debug_write    = wr;
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!debug_done && lat < 10);
    chk("access_latency", 32'(lat), 32'(exp_lat));
    tick();
    debug_read  = 1'b0;
    debug_write = 1'b0;
    tick();
  endtask

  task automatic resume();
    resumereq = 1'b1;
    exp_redir.push_back(m_dpc);
    tick();
    chk("resume_redirect_valid", 32'(redirect_valid), 32'd1);
    chk("resume_ack", 32'(resumeack), 32'd1);
    chk("resume_haltack", 32'(core_haltack), 32'd0);
    chk("resume_stall", 32'(pipe_stall), 32'd0);
    resumereq = 1'b0;
    tick();
    chk("running_redirect", 32'(redirect_valid), 32'd0);
    chk("running_stall", 32'(pipe_stall), 32'd0);
    m_halted = 0;
  endtask

  task automatic random_access();
    int          k;
    logic [12:0] idx;
    logic [31:0] wd;
    bit          both;
    k    = $urandom_range(0, 7);
    wd   = $urandom;
    both = ($urandom_range(0, 3) == 0);
    case (k)
      0, 1: access(both, 1, 13'(13'h1000 + $urandom_range(0, 31)), wd);
      2:    access(1, 0, 13'(13'h1000 + $urandom_range(0, 31)), wd);
      3:    access(both, 1, 13'h07B0, wd);
      4:    access(1, 0, 13'h07B0, wd);
      5:    access(both, 1, 13'h07B1, wd);
      6:    access(1, 0, 13'h07B1, wd);
      default: begin
        do idx = 13'($urandom_range(0, 13'h1FFF));
        while ((idx >= 13'h1000 && idx <= 13'h101F) ||
               idx == 13'h07B0 || idx == 13'h07B1);
        access(1, both, idx, wd);
      end
    endcase
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset          = 1'b0;
    haltreq        = 1'b0;
    resumereq      = 1'b0;
    register_index = '0;
    debug_read     = 1'b0;
    debug_write    = 1'b0;
    debug_wdata    = '0;
    pipe_empty     = 1'b1;
    core_pc        = '0;
    model_reset();
    tick();
    tick();
    check_outputs_zero("reset");
    reset  = 1'b1;
    mon_en = 1;
    tick();

    access(1, 0, 13'h1001, 32'h0);
    halt(32'h0000_0200, 0);
    access(1, 0, 13'h07B1, 32'h0);
    access(1, 0, 13'h07B0, 32'h0);
    access(0, 1, 13'h1005, 32'hDEAD_BEEF);
    access(1, 0, 13'h1005, 32'h0);
    access(1, 0, 13'h0300, 32'h0);
    access(0, 1, 13'h1000, 32'h1234_5678);
    access(1, 0, 13'h1000, 32'h0);
    access(0, 1, 13'h07B0, 32'hFFFF_FFFF);
    access(1, 0, 13'h07B0, 32'h0);
    access(1, 1, 13'h07B1, 32'h0000_0400);

    haltreq   = 1'b1;
    resumereq = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("halt_wins_ack", 32'(core_haltack), 32'd1);
    end
    haltreq   = 1'b0;
    resumereq = 1'b0;
    tick();
    resume();

    halt(32'h0000_0300, 5);
    access(1, 0, 13'h07B1, 32'h0);
    resume();

    for (int r = 0; r < 6; r++) begin
      if ($urandom_range(0, 1) == 1)
        access(1, 0, 13'(13'h1000 + $urandom_range(0, 31)), 32'h0);
      halt({$urandom_range(0, 32'h3FFF_FFFF), 2'b00},
           $urandom_range(0, 4));
      for (int j = 0; j < 8; j++) random_access();
      resume();
    end

    haltreq    = 1'b1;
    pipe_empty = 1'b0;
    tick();
    tick();
    chk("halting_stall", 32'(pipe_stall), 32'd1);
    reset = 1'b0;
    tick();
    check_outputs_zero("reset_in_halting");
    haltreq = 1'b0;
    reset   = 1'b1;
    model_reset();
    tick();
    halt(32'h0000_0800, 1);
    access(1, 0, 13'h07B0, 32'h0);
    access(1, 0, 13'h1005, 32'h0);
    resume();

    tick();
    tick();
    chk("pending_done", 32'(exp_done.size()), 32'd0);
    chk("pending_wr", 32'(exp_wr.size()), 32'd0);
    chk("pending_redir", 32'(exp_redir.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
